// File: rtl/ftg_pkg.sv
// ============================================================================
//  Module  : ftg_pkg
//  Brief   : Shared state encoding and arithmetic helpers for folded_threshold_gate.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ftg_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Smallest count that is strictly more than half of n.
    function automatic int maj_thr(input int n);
        return n / 2 + 1;
    endfunction

    function automatic int unsigned chunk_popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/folded_threshold_gate_if.sv
// ============================================================================
//  Module  : folded_threshold_gate_if
//  Brief   : Operand/result handshake bundle; cnt exists only with FTG_COUNT_OUT_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface folded_threshold_gate_if #(
    parameter int N_IN = 5
);
    localparam int CNT_W = $clog2(N_IN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  x;
    logic             thr_sel;
    logic [CNT_W-1:0] thr;
    logic             out_valid;
    logic             out_ready;
    logic             y;
`ifdef FTG_COUNT_OUT_EN
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid, x, thr_sel, thr, out_ready,
        input  in_ready, out_valid, y, cnt
    );
    modport slave (
        input  in_valid, x, thr_sel, thr, out_ready,
        output in_ready, out_valid, y, cnt
    );
`else
    modport master (
        output in_valid, x, thr_sel, thr, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, x, thr_sel, thr, out_ready,
        output in_ready, out_valid, y
    );
`endif

endinterface

`default_nettype wire

// File: rtl/ftg_chunk_popcount.sv
// ============================================================================
//  Module  : ftg_chunk_popcount
//  Brief   : Combinational popcount of one FOLD_W-bit chunk, widened to CNT_W.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ftg_chunk_popcount
    import ftg_pkg::*;
#(
    parameter int FOLD_W = 2,
    parameter int CNT_W  = 3
) (
    input  wire logic [FOLD_W-1:0] chunk_i,
    output logic      [CNT_W-1:0]  cnt_o
);

    logic [31:0] w_ext;

    assign w_ext = 32'(chunk_i);
    assign cnt_o = CNT_W'(chunk_popcount(w_ext));

endmodule

`default_nettype wire

// File: rtl/folded_threshold_gate.sv
// ============================================================================
//  Module  : folded_threshold_gate
//  Brief   : Folded N-input threshold/majority gate, FOLD_W bits summed per cycle.
//            Define FTG_COUNT_OUT_EN to expose the final popcount on cnt.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module folded_threshold_gate
    import ftg_pkg::*;
#(
    parameter int N_IN   = 5,
    parameter int FOLD_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    folded_threshold_gate_if.slave bus
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int N_FOLD = (N_IN + FOLD_W - 1) / FOLD_W;
    localparam int PAD_W  = N_FOLD * FOLD_W;
    localparam int IDX_W  = (N_FOLD > 1) ? $clog2(N_FOLD) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_FOLD - 1);
    localparam logic [CNT_W-1:0] c_MAJ_THR  = CNT_W'(maj_thr(N_IN));

    logic [1:0]       state_q, state_d;
    logic [PAD_W-1:0] x_q,     x_d;
    logic [CNT_W-1:0] thr_q,   thr_d;
    logic [CNT_W-1:0] acc_q,   acc_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             y_q,     y_d;

    logic [CNT_W-1:0] w_chunk_cnt;
    logic [CNT_W-1:0] w_acc_next;

    // The operand shifts right each fold cycle, so the active chunk is always
    // the low FOLD_W bits; zero padding above N_IN falls out of the shift.
    ftg_chunk_popcount #(
        .FOLD_W (FOLD_W),
        .CNT_W  (CNT_W)
    ) u_chunk (
        .chunk_i (x_q[FOLD_W-1:0]),
        .cnt_o   (w_chunk_cnt)
    );

    assign w_acc_next = acc_q + w_chunk_cnt;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        thr_d   = thr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = PAD_W'(bus.x);
                    thr_d   = bus.thr_sel ? bus.thr : c_MAJ_THR;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = w_acc_next;
                x_d   = x_q >> FOLD_W;
                idx_d = idx_q + 1'b1;
                if (idx_q == c_LAST_IDX) begin
                    y_d     = (w_acc_next >= thr_q);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            thr_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            thr_q   <= thr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.y         = y_q;

`ifdef FTG_COUNT_OUT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_ACC && idx_q == c_LAST_IDX) begin
            cnt_q <= w_acc_next;
        end
    end

    assign bus.cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_folded_threshold_gate.sv
// ============================================================================
//  Module  : tb_folded_threshold_gate
//  Brief   : Directed self-checking bench: a 5/2 gate and an 8/3 gate side by side.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_folded_threshold_gate;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    folded_threshold_gate_if #(.N_IN(5)) if_a ();
    folded_threshold_gate_if #(.N_IN(8)) if_b ();

    folded_threshold_gate #(.N_IN(5), .FOLD_W(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    folded_threshold_gate #(.N_IN(8), .FOLD_W(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int pop8(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Presents one operand, counts edges from the accept edge until out_valid
    // is seen, and returns y (and cnt when built) sampled in DONE.
    task automatic run_op(input bit use_b, input logic [7:0] xv, input logic sel,
                          input logic [3:0] thv, output logic yv, output int lat,
                          output logic [3:0] cv);
        logic ov;
        if (use_b) begin
            if_b.x = xv; if_b.thr_sel = sel; if_b.thr = thv; if_b.in_valid = 1'b1;
        end else begin
            if_a.x = xv[4:0]; if_a.thr_sel = sel; if_a.thr = thv[2:0]; if_a.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
        lat = 1;
        ov  = use_b ? if_b.out_valid : if_a.out_valid;
        while (!ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ov = use_b ? if_b.out_valid : if_a.out_valid;
        end
        if (!ov) check("op_timeout", 32'(ov), 32'd1);
        yv = use_b ? if_b.y : if_a.y;
        cv = 4'd0;
`ifdef FTG_COUNT_OUT_EN
        cv = use_b ? if_b.cnt : 4'(if_a.cnt);
`endif
    endtask

    // Completes a DONE cycle when out_ready is high.
    task automatic finish_op();
        @(posedge clk); #1;
    endtask

    logic       yv;
    int         lat;
    logic [3:0] cv;
    logic [4:0] xv5;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        if_a.in_valid = 1'b0; if_a.x = '0; if_a.thr_sel = 1'b0; if_a.thr = '0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.x = '0; if_b.thr_sel = 1'b0; if_b.thr = '0; if_b.out_ready = 1'b1;

        #12;
        check("rst_in_ready",  32'(if_a.in_ready),  32'd1);
        check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_y",         32'(if_a.y),         32'd0);
        check("rst_b_ready",   32'(if_b.in_ready),  32'd1);
`ifdef FTG_COUNT_OUT_EN
        check("rst_cnt",       32'(if_a.cnt),       32'd0);
`endif
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Majority over every 5-bit operand
        for (int i = 0; i < 32; i++) begin
            xv5 = 5'(i);
            run_op(1'b0, {3'b000, xv5}, 1'b0, 4'd0, yv, lat, cv);
            check($sformatf("maj_y_x%02h", i), 32'(yv), 32'(pop8({3'b000, xv5}) >= 3));
            check($sformatf("maj_lat_x%02h", i), 32'(lat), 32'd4);
            finish_op();
        end

        // Programmable threshold, x = 10110 (three ones)
        run_op(1'b0, 8'b0001_0110, 1'b1, 4'd3, yv, lat, cv); check("thr3_y", 32'(yv), 32'd1); finish_op();
        run_op(1'b0, 8'b0001_0110, 1'b1, 4'd4, yv, lat, cv); check("thr4_y", 32'(yv), 32'd0); finish_op();
        run_op(1'b0, 8'b0001_0110, 1'b1, 4'd0, yv, lat, cv); check("thr0_y", 32'(yv), 32'd1); finish_op();
        run_op(1'b0, 8'b0001_0110, 1'b1, 4'd7, yv, lat, cv); check("thr7_y", 32'(yv), 32'd0); finish_op();

        // Consumer stall with a competing operand held by the source
        if_a.out_ready = 1'b0;
        run_op(1'b0, 8'b0001_1100, 1'b0, 4'd0, yv, lat, cv);
        check("stall_first_y", 32'(yv), 32'd1);
        if_a.x = 5'b00000; if_a.thr_sel = 1'b0; if_a.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall_hold_%0d", k),
                  {29'd0, if_a.out_valid, if_a.y, if_a.in_ready}, {29'd0, 1'b1, 1'b1, 1'b0});
        end
        if_a.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_idle", {30'd0, if_a.in_ready, if_a.out_valid}, {30'd0, 1'b1, 1'b0});
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        check("held_op_taken", 32'(if_a.in_ready), 32'd0);
        lat = 0;
        while (!if_a.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held_op_valid", 32'(if_a.out_valid), 32'd1);
        check("held_op_y",     32'(if_a.y),         32'd0);
        finish_op();

        // Reset during the second fold cycle
        if_a.x = 5'b11111; if_a.thr_sel = 1'b0; if_a.in_valid = 1'b1;
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(if_a.out_valid), 32'd0);
        check("midrst_in_ready",  32'(if_a.in_ready),  32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 8'b0000_0011, 1'b0, 4'd0, yv, lat, cv);
        check("after_rst_y", 32'(yv), 32'd0);
        finish_op();

        // Eight inputs folded three at a time, last chunk padded
        run_op(1'b1, 8'hF0, 1'b0, 4'd0, yv, lat, cv);
        check("b_F0_y",   32'(yv),  32'd0);
        check("b_F0_lat", 32'(lat), 32'd4);
`ifdef FTG_COUNT_OUT_EN
        check("b_F0_cnt", 32'(cv),  32'd4);
`endif
        finish_op();
        run_op(1'b1, 8'hF8, 1'b0, 4'd0, yv, lat, cv);
        check("b_F8_y",   32'(yv),  32'd1);
        check("b_F8_lat", 32'(lat), 32'd4);
        finish_op();

`ifdef FTG_COUNT_OUT_EN
        run_op(1'b0, 8'b0001_1111, 1'b0, 4'd0, yv, lat, cv);
        check("cnt_all_ones", 32'(cv), 32'd5);
        check("cnt_all_y",    32'(yv), 32'd1);
        finish_op();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
